// File: rtl/accum_seq_pkg.sv
// Shared types and constants for the accumulate sequencer.
package accum_seq_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 8;
  localparam logic [DEF_WIDTH-1:0] SAT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/accum_sequencer_if.sv
// Request/result handshake bundle; master = command source and consumer, slave = sequencer.
interface accum_sequencer_if import accum_seq_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_operand;
  logic [CNT_W-1:0] req_count;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_ovf;

  modport master (
    output req_valid, req_operand, req_count, res_ready,
    input  req_ready, res_valid, res_sum, res_ovf
  );

  modport slave (
    input  req_valid, req_operand, req_count, res_ready,
    output req_ready, res_valid, res_sum, res_ovf
  );
endinterface

// File: rtl/accum_datapath.sv
// Sum register with adder and sticky overflow; ACCUM_SAT_EN selects saturating add.
module accum_datapath import accum_seq_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

`ifdef ACCUM_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic [WIDTH-1:0] MAX_VAL = (WIDTH == DEF_WIDTH) ? WIDTH'(SAT_MAX) : {WIDTH{1'b1}};

  logic [WIDTH-1:0] sum_r;
  logic             ovf_r;
  logic [WIDTH:0]   add_s;
  logic [WIDTH-1:0] sum_next_s;

  // Adder with optional clamp; a saturated sum re-carries on any nonzero operand, so it stays at max.
  always_comb begin
    add_s      = {1'b0, sum_r} + {1'b0, operand};
    sum_next_s = add_s[WIDTH-1:0];
    if (SAT_EN && add_s[WIDTH]) begin
      sum_next_s = MAX_VAL;
    end else begin
      sum_next_s = add_s[WIDTH-1:0];
    end
  end

  // Sum and overflow registers.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      sum_r <= {WIDTH{1'b0}};
      ovf_r <= 1'b0;
    end else if (en) begin
      sum_r <= sum_next_s;
      ovf_r <= ovf_r | add_s[WIDTH];
    end
  end

  assign sum = sum_r;
  assign ovf = ovf_r;

endmodule

// File: rtl/accum_sequencer.sv
// Job sequencer driving the accumulate datapath's clear/enable; ACCUM_SAT_EN (in accum_datapath) selects saturation.
module accum_sequencer import accum_seq_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  accum_sequencer_if.slave   bus,
  output logic               busy
);

  state_e           state_r;
  state_e           state_next_s;
  logic [CNT_W-1:0] remaining_r;
  logic [WIDTH-1:0] operand_r;
  logic             load_s;
  logic             clr_s;
  logic             en_s;
  logic [WIDTH-1:0] sum_s;
  logic             ovf_s;

  // Next-state and datapath control decode.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    clr_s        = 1'b0;
    en_s         = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.req_valid) begin
          load_s       = 1'b1;
          clr_s        = 1'b1;
          state_next_s = (bus.req_count != {CNT_W{1'b0}}) ? RUN : DONE;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        en_s = 1'b1;
        if (remaining_r == CNT_W'(1)) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, repeat count and latched operand.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      remaining_r <= {CNT_W{1'b0}};
      operand_r   <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_next_s;
      if (load_s) begin
        remaining_r <= bus.req_count;
        operand_r   <= bus.req_operand;
      end else if (en_s) begin
        remaining_r <= remaining_r - CNT_W'(1);
      end
    end
  end

  accum_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr_s),
    .en      (en_s),
    .operand (operand_r),
    .sum     (sum_s),
    .ovf     (ovf_s)
  );

  assign bus.req_ready = (state_r == IDLE);
  assign bus.res_valid = (state_r == DONE);
  assign bus.res_sum   = sum_s;
  assign bus.res_ovf   = ovf_s;
  assign busy          = (state_r != IDLE);

endmodule
